mux_sram_bridge: RTL and testbench

Parametrised successor to the CPU's nibble-multiplexed external SRAM path, sitting between the CPU's narrow pin bus and an internal synchronous memory array.
- Addresses and data arrive as BEAT_W-wide beats over a single command channel, and read data returns one beat per cycle.
- Generalises the fixed 12-bit-address, two-nibble scheme to arbitrary address, data and beat widths.
- Adds a shadowed address commit, an optional auto-increment mode and a reserved-command error pulse.

---
 rtl/mux_sram_bridge.sv | 147 ++++++++++++++
 tb/tb_mux_sram_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_sram_bridge.sv
// Beat-multiplexed bridge from a narrow command bus to a synchronous word memory.
// Addresses and write data arrive LS beat first; read data returns one beat per READ, one cycle later.
module mux_sram_bridge #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int BEAT_W   = 4,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    input  logic [BEAT_W-1:0] cmd_data,
    output logic [BEAT_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              err,
    output logic [ADDR_W-1:0] addr
);

    localparam int ABEATS = (ADDR_W + BEAT_W - 1) / BEAT_W;
    localparam int DBEATS = DATA_W / BEAT_W;
    localparam int AC_W   = (ABEATS > 1) ? $clog2(ABEATS) : 1;
    localparam int DC_W   = (DBEATS > 1) ? $clog2(DBEATS) : 1;

    typedef enum logic [1:0] {
        CMD_ADDR  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    cmd_e              cmd_t;
    logic [AC_W-1:0]   a_cnt;
    logic [DC_W-1:0]   d_cnt;
    logic [DC_W-1:0]   r_cnt;
    logic [ADDR_W-1:0] shadow, shadow_nxt;
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] acc, acc_nxt, wr_word, rd_word;
    logic [BEAT_W-1:0] rd_beat;
    logic              a_last, d_last, r_last, mem_we;

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    assign cmd_t    = cmd_e'(cmd);
    assign a_last   = (a_cnt == AC_W'(ABEATS - 1));
    assign d_last   = (d_cnt == DC_W'(DBEATS - 1));
    assign r_last   = (r_cnt == DC_W'(DBEATS - 1));
    assign addr_inc = (AUTO_INC != 0) ? addr + ADDR_W'(1) : addr;
    // Gated by rst so a WRITE presented while reset is held never reaches the array.
    assign mem_we   = rst && cmd_valid && (cmd_t == CMD_WRITE) && d_last;

    always_comb begin
        shadow_nxt = shadow;
        acc_nxt    = acc;
        wr_word    = acc;
        rd_beat    = '0;
        rd_word    = mem[addr];
        for (int unsigned j = 0; j < ADDR_W; j++) begin
            if (j / BEAT_W == 32'(a_cnt)) shadow_nxt[j] = cmd_data[j % BEAT_W];
        end
        for (int unsigned j = 0; j < DATA_W; j++) begin
            if (j / BEAT_W == 32'(d_cnt)) acc_nxt[j] = cmd_data[j % BEAT_W];
        end
        for (int unsigned j = 0; j < BEAT_W; j++) begin
            wr_word[(DBEATS - 1) * BEAT_W + j] = cmd_data[j];
        end
        for (int unsigned i = 0; i < DBEATS; i++) begin
            if (32'(r_cnt) == i) rd_beat = rd_word[i * BEAT_W +: BEAT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            shadow   <= '0;
            acc      <= '0;
            a_cnt    <= '0;
            d_cnt    <= '0;
            r_cnt    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            err      <= 1'b0;
            if (cmd_valid) begin
                // Any non-ADDR beat abandons a partially shifted address.
                if (cmd_t != CMD_ADDR) begin
                    a_cnt  <= '0;
                    shadow <= '0;
                end
                case (cmd_t)
                    CMD_ADDR: begin
                        d_cnt <= '0;
                        r_cnt <= '0;
                        if (a_last) begin
                            addr   <= shadow_nxt;
                            shadow <= '0;
                            a_cnt  <= '0;
                        end else begin
                            shadow <= shadow_nxt;
                            a_cnt  <= a_cnt + AC_W'(1);
                        end
                    end
                    CMD_WRITE: begin
                        r_cnt <= '0;
                        if (d_last) begin
                            d_cnt   <= '0;
                            acc     <= '0;
                            wr_done <= 1'b1;
                            addr    <= addr_inc;
                        end else begin
                            acc   <= acc_nxt;
                            d_cnt <= d_cnt + DC_W'(1);
                        end
                    end
                    CMD_READ: begin
                        d_cnt    <= '0;
                        acc      <= '0;
                        rd_valid <= 1'b1;
                        rd_data  <= rd_beat;
                        if (r_last) begin
                            r_cnt <= '0;
                            addr  <= addr_inc;
                        end else begin
                            r_cnt <= r_cnt + DC_W'(1);
                        end
                    end
                    default: begin
                        err   <= 1'b1;
                        d_cnt <= '0;
                        r_cnt <= '0;
                        acc   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_sram_bridge.sv
// Directed bench for mux_sram_bridge: default build plus a 16-bit-word, no-increment build.
module tb_mux_sram_bridge;

    localparam logic [1:0] C_ADDR = 2'b00;
    localparam logic [1:0] C_WR   = 2'b01;
    localparam logic [1:0] C_RD   = 2'b10;
    localparam logic [1:0] C_RSV  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;

    logic        valid_a, rd_valid_a, wr_done_a, err_a;
    logic [1:0]  cmd_a;
    logic [3:0]  data_a, rd_data_a;
    logic [11:0] addr_a;

    logic        valid_b, rd_valid_b, wr_done_b, err_b;
    logic [1:0]  cmd_b;
    logic [3:0]  data_b, rd_data_b;
    logic [9:0]  addr_b;

    int checks = 0;
    int errors = 0;
    logic [3:0] q_a [$];
    logic [3:0] q_b [$];

    always #5 clk = ~clk;

    mux_sram_bridge #(.ADDR_W(12), .DATA_W(8), .BEAT_W(4), .AUTO_INC(1)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd(cmd_a), .cmd_data(data_a),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wr_done(wr_done_a), .err(err_a),
        .addr(addr_a)
    );

    mux_sram_bridge #(.ADDR_W(10), .DATA_W(16), .BEAT_W(4), .AUTO_INC(0)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd(cmd_b), .cmd_data(data_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_done(wr_done_b), .err(err_b),
        .addr(addr_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [1:0] c, input logic [3:0] d, input logic [3:0] exp_rd);
        logic [3:0] e;
        valid_a = 1'b1;
        cmd_a   = c;
        data_a  = d;
        if (c == C_RD) q_a.push_back(exp_rd);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        check("rd_valid_a", 32'(rd_valid_a), 32'(c == C_RD));
        check("err_a", 32'(err_a), 32'(c == C_RSV));
        if (rd_valid_a && q_a.size() > 0) begin
            e = q_a.pop_front();
            check("rd_data_a", 32'(rd_data_a), 32'(e));
        end
    endtask

    task automatic send_b(input logic [1:0] c, input logic [3:0] d, input logic [3:0] exp_rd);
        logic [3:0] e;
        valid_b = 1'b1;
        cmd_b   = c;
        data_b  = d;
        if (c == C_RD) q_b.push_back(exp_rd);
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        check("rd_valid_b", 32'(rd_valid_b), 32'(c == C_RD));
        if (rd_valid_b && q_b.size() > 0) begin
            e = q_b.pop_front();
            check("rd_data_b", 32'(rd_data_b), 32'(e));
        end
    endtask

    task automatic addr3_a(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2);
        send_a(C_ADDR, b0, 4'h0);
        send_a(C_ADDR, b1, 4'h0);
        send_a(C_ADDR, b2, 4'h0);
    endtask

    task automatic idle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        valid_a = 1'b0; cmd_a = 2'b00; data_a = 4'h0;
        valid_b = 1'b0; cmd_b = 2'b00; data_b = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr_a", 32'(addr_a), 32'h0);
        check("rst_rd_valid_a", 32'(rd_valid_a), 32'h0);
        check("rst_rd_data_a", 32'(rd_data_a), 32'h0);
        check("rst_wr_done_a", 32'(wr_done_a), 32'h0);
        check("rst_err_a", 32'(err_a), 32'h0);
        check("rst_addr_b", 32'(addr_b), 32'h0);
        rst = 1'b1;

        // address commits only on the third beat
        send_a(C_ADDR, 4'h5, 4'h0);
        check("addr_beat1", 32'(addr_a), 32'h000);
        send_a(C_ADDR, 4'hA, 4'h0);
        check("addr_beat2", 32'(addr_a), 32'h000);
        send_a(C_ADDR, 4'h3, 4'h0);
        check("addr_beat3", 32'(addr_a), 32'h3A5);

        send_a(C_WR, 4'hC, 4'h0);
        check("wr_done_first", 32'(wr_done_a), 32'h0);
        send_a(C_WR, 4'h7, 4'h0);
        check("wr_done_last", 32'(wr_done_a), 32'h1);
        check("addr_after_wr", 32'(addr_a), 32'h3A6);
        idle();
        check("wr_done_idle", 32'(wr_done_a), 32'h0);

        addr3_a(4'h5, 4'hA, 4'h3);
        check("addr_reload", 32'(addr_a), 32'h3A5);
        send_a(C_RD, 4'h0, 4'hC);
        check("addr_mid_read", 32'(addr_a), 32'h3A5);
        send_a(C_RD, 4'h0, 4'h7);
        check("addr_after_read", 32'(addr_a), 32'h3A6);

        // top-of-memory wrap
        addr3_a(4'hF, 4'hF, 4'hF);
        check("addr_fff", 32'(addr_a), 32'hFFF);
        send_a(C_WR, 4'h1, 4'h0);
        send_a(C_WR, 4'h2, 4'h0);
        check("wr_done_fff", 32'(wr_done_a), 32'h1);
        check("addr_wrap_wr", 32'(addr_a), 32'h000);
        addr3_a(4'hF, 4'hF, 4'hF);
        send_a(C_RD, 4'h0, 4'h1);
        send_a(C_RD, 4'h0, 4'h2);
        check("addr_wrap_rd", 32'(addr_a), 32'h000);

        // partial address abandoned by a WRITE
        addr3_a(4'h0, 4'h1, 4'h0);
        check("addr_010", 32'(addr_a), 32'h010);
        send_a(C_ADDR, 4'h1, 4'h0);
        send_a(C_ADDR, 4'h2, 4'h0);
        check("addr_partial", 32'(addr_a), 32'h010);
        send_a(C_WR, 4'h9, 4'h0);
        send_a(C_WR, 4'h9, 4'h0);
        check("wr_done_abort", 32'(wr_done_a), 32'h1);
        check("addr_abort", 32'(addr_a), 32'h011);
        addr3_a(4'h0, 4'h1, 4'h0);
        send_a(C_RD, 4'h0, 4'h9);
        send_a(C_RD, 4'h0, 4'h9);

        // reserved command resets the read beat counter
        addr3_a(4'h5, 4'hA, 4'h3);
        send_a(C_RD, 4'h0, 4'hC);
        send_a(C_RSV, 4'h0, 4'h0);
        check("addr_after_err", 32'(addr_a), 32'h3A5);
        idle();
        check("err_idle", 32'(err_a), 32'h0);
        send_a(C_RD, 4'h0, 4'hC);
        send_a(C_RD, 4'h0, 4'h7);
        check("addr_err_seq", 32'(addr_a), 32'h3A6);

        // 16-bit words, no auto-increment, read straight after write
        send_b(C_ADDR, 4'h4, 4'h0);
        send_b(C_ADDR, 4'h0, 4'h0);
        send_b(C_ADDR, 4'h1, 4'h0);
        check("addr_b_104", 32'(addr_b), 32'h104);
        send_b(C_WR, 4'h1, 4'h0);
        check("wr_done_b1", 32'(wr_done_b), 32'h0);
        send_b(C_WR, 4'h2, 4'h0);
        send_b(C_WR, 4'h3, 4'h0);
        check("wr_done_b3", 32'(wr_done_b), 32'h0);
        send_b(C_WR, 4'h4, 4'h0);
        check("wr_done_b4", 32'(wr_done_b), 32'h1);
        check("addr_b_hold_wr", 32'(addr_b), 32'h104);
        send_b(C_RD, 4'h0, 4'h1);
        send_b(C_RD, 4'h0, 4'h2);
        send_b(C_RD, 4'h0, 4'h3);
        send_b(C_RD, 4'h0, 4'h4);
        check("addr_b_hold_rd", 32'(addr_b), 32'h104);
        check("err_b", 32'(err_b), 32'h0);

        // asynchronous reset between write beats
        addr3_a(4'h0, 4'h4, 4'h0);
        send_a(C_WR, 4'h5, 4'h0);
        send_a(C_WR, 4'h6, 4'h0);
        addr3_a(4'h0, 4'h4, 4'h0);
        check("addr_040", 32'(addr_a), 32'h040);
        send_a(C_WR, 4'h1, 4'h0);
        #3;
        rst = 1'b0;
        #1;
        check("async_addr_a", 32'(addr_a), 32'h0);
        check("async_rd_data_a", 32'(rd_data_a), 32'h0);
        check("async_rd_valid_a", 32'(rd_valid_a), 32'h0);
        check("async_addr_b", 32'(addr_b), 32'h0);
        valid_a = 1'b1;
        cmd_a   = C_WR;
        data_a  = 4'h2;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        check("held_wr_done_a", 32'(wr_done_a), 32'h0);
        rst = 1'b1;
        addr3_a(4'h0, 4'h4, 4'h0);
        send_a(C_RD, 4'h0, 4'h5);
        send_a(C_RD, 4'h0, 4'h6);

        check("q_a_drained", 32'(q_a.size()), 32'h0);
        check("q_b_drained", 32'(q_b.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
